spart_rx: RTL and testbench

//   Serial receive engine of the SPART: deserialises 8N1 frames on rxd using the
//   16x oversampling tick from the baud generator and holds the byte in a one-entry

---
 rtl/spart_pkg.sv | 22 ++
 rtl/spart_sync.sv | 31 +++
 rtl/spart_rx.sv | 126 ++++++++++++
 tb/tb_spart_rx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spart_pkg
// Description : Shared SPART types and default sizing used by the receiver,
//               transmitter and baud generator.
// Revision    : 1.0 - initial release
// ============================================================================
package spart_pkg;

  localparam int DEF_OVERSAMPLE  = 16;
  localparam int DEF_DATA_BITS   = 8;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/spart_sync.sv
`default_nettype none
// ============================================================================
// Module      : spart_sync
// Description : SYNC_STAGES-deep single-bit synchroniser. Flops reset to 1 so
//               an idle-high serial line is not seen as a start bit.
// Revision    : 1.0 - initial release
// ============================================================================
module spart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '1;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spart_rx.sv
`default_nettype none
// ============================================================================
// Module      : spart_rx
// Description : SPART serial receive engine. Deserialises 8N1 frames using
//               the oversampling tick and holds the result in a one-entry
//               buffer with data-available, framing-error and overrun flags.
// Revision    : 1.0 - initial release
// ============================================================================
module spart_rx
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  input  logic                 baud_en,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  rx_state_t              state;
  rx_state_t              state_next;
  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   rxd_s;
  logic                   take_bit;
  logic                   complete;

  spart_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus the bit-sample and frame-complete strobes.
  always_comb begin
    state_next = state;
    take_bit   = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (baud_en && !rxd_s) state_next = START;
      end
      START: begin
        // Mid start bit: a high line here was a glitch, not a frame.
        if (baud_en && tick_cnt == HALF_LAST) state_next = rxd_s ? IDLE : DATA;
      end
      DATA: begin
        if (baud_en && tick_cnt == TICK_LAST) begin
          take_bit = 1'b1;
          if (bit_cnt == BIT_LAST) state_next = STOP;
        end
      end
      STOP: begin
        // Leave mid stop bit so a back-to-back start edge is caught.
        if (baud_en && tick_cnt == TICK_LAST) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Counters, shift register and the receive buffer with its flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rda       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (state_next != state) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else if (baud_en && state != IDLE) begin
        tick_cnt <= tick_cnt + 1'b1;
        if (take_bit) bit_cnt <= bit_cnt + 1'b1;
      end

      if (take_bit) shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};

      // A completing frame takes priority over a simultaneous bus read.
      if (complete) begin
        rx_data   <= shift_reg;
        rda       <= 1'b1;
        frame_err <= ~rxd_s;
        overrun   <= rda & ~rd_ack;
      end else if (rd_ack && rda) begin
        rda       <= 1'b0;
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_spart_rx
// Description : Self-checking bench for spart_rx. Frames are driven with a
//               baud tick every 4 clocks (64 clocks per bit); expected buffer
//               contents are queued when a frame starts and popped when the
//               frame completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spart_rx;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       ovr;
  } exp_t;

  // Cycle offset from the start-bit edge at which the result becomes visible,
  // and the offset at which a same-cycle rd_ack must be driven.
  localparam int DONE_IDX = 610;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       baud_en = 1'b0;
  logic       rd_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rda;
  logic       frame_err;
  logic       overrun;

  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  logic model_rda = 1'b0;
  exp_t sb[$];

  spart_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .baud_en   (baud_en),
    .rd_ack    (rd_ack),
    .rx_data   (rx_data),
    .rda       (rda),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs change 1 ns after the edge.
  task automatic step_clk();
    @(posedge clk);
    #1;
    cyc++;
    baud_en = (cyc % 4 == 0);
  endtask

  task automatic align();
    while (cyc % 4 != 2) step_clk();
  endtask

  // Drive one full frame; the expected buffer state is queued up front and
  // checked on the cycle the frame completes.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int ack_at);
    logic [9:0] bits;
    exp_t e;
    exp_t got;
    bits   = {stop_bit, data, 1'b0};
    e.data = data;
    e.ferr = ~stop_bit;
    e.ovr  = model_rda && (ack_at != DONE_IDX);
    sb.push_back(e);
    model_rda = 1'b1;
    align();
    for (int n = 0; n < 640; n++) begin
      rxd    = bits[n / 64];
      rd_ack = (n == ack_at);
      step_clk();
      if (n == DONE_IDX) begin
        if (sb.size() == 0) begin
          checks++; fails++;
          $display("FAIL scoreboard: empty queue at completion");
        end else begin
          got = sb.pop_front();
          checks++;
          if (rx_data !== got.data) begin
            fails++;
            $display("FAIL frame_data: got %h expected %h", rx_data, got.data);
          end
          checks++;
          if (rda !== 1'b1) begin
            fails++;
            $display("FAIL frame_rda: got %b expected 1", rda);
          end
          checks++;
          if (frame_err !== got.ferr) begin
            fails++;
            $display("FAIL frame_err (data %h): got %b expected %b", got.data, frame_err, got.ferr);
          end
          checks++;
          if (overrun !== got.ovr) begin
            fails++;
            $display("FAIL frame_overrun (data %h): got %b expected %b", got.data, overrun, got.ovr);
          end
        end
      end
    end
    rd_ack = 1'b0;
    rxd    = 1'b1;
  endtask

  // Bus read of the buffer; flags must clear, the data must hold.
  task automatic ack_and_check(input logic [7:0] held);
    rd_ack = 1'b1;
    step_clk();
    rd_ack = 1'b0;
    model_rda = 1'b0;
    checks++;
    if (rda !== 1'b0) begin
      fails++;
      $display("FAIL ack_rda: got %b expected 0", rda);
    end
    checks++;
    if (rx_data !== held) begin
      fails++;
      $display("FAIL ack_data_hold: got %h expected %h", rx_data, held);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL ack_frame_err: got %b expected 0", frame_err);
    end
    checks++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL ack_overrun: got %b expected 0", overrun);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step_clk();
    checks++;
    if ({rx_data, rda, frame_err, overrun} !== 11'h0) begin
      fails++;
      $display("FAIL reset_in: got %h/%b%b%b expected 00/000", rx_data, rda, frame_err, overrun);
    end
    rst_n = 1'b1;
    repeat (40) step_clk();
    checks++;
    if ({rx_data, rda, frame_err, overrun} !== 11'h0) begin
      fails++;
      $display("FAIL reset_out: got %h/%b%b%b expected 00/000", rx_data, rda, frame_err, overrun);
    end
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b1, -1);
    ack_and_check(8'hA5);
  endtask

  task automatic test_false_start();
    align();
    rxd = 1'b0;
    repeat (16) step_clk();
    rxd = 1'b1;
    repeat (100) step_clk();
    checks++;
    if (rda !== 1'b0) begin
      fails++;
      $display("FAIL false_start_rda: got %b expected 0", rda);
    end
    checks++;
    if (rx_data !== 8'hA5) begin
      fails++;
      $display("FAIL false_start_data: got %h expected a5", rx_data);
    end
    send_frame(8'h5A, 1'b1, -1);
    ack_and_check(8'h5A);
  endtask

  task automatic test_frame_error();
    send_frame(8'h3C, 1'b0, -1);
    ack_and_check(8'h3C);
    // Let the low stop bit's spurious start detection die out.
    repeat (100) step_clk();
    checks++;
    if (rda !== 1'b0) begin
      fails++;
      $display("FAIL post_ferr_idle_rda: got %b expected 0", rda);
    end
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    ack_and_check(8'h22);
  endtask

  task automatic test_back_to_back();
    send_frame(8'h55, 1'b1, -1);
    send_frame(8'hAA, 1'b1, DONE_IDX);
    step_clk();
    checks++;
    if (rda !== 1'b1 || rx_data !== 8'hAA) begin
      fails++;
      $display("FAIL b2b_hold: got rda %b data %h expected 1 aa", rda, rx_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits;
    bits = {1'b1, 8'hF0, 1'b0};
    align();
    for (int n = 0; n < 340; n++) begin
      rxd = bits[n / 64];
      step_clk();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_data, rda, frame_err, overrun} !== 11'h0) begin
      fails++;
      $display("FAIL midframe_reset: got %h/%b%b%b expected 00/000", rx_data, rda, frame_err, overrun);
    end
    step_clk();
    step_clk();
    rst_n = 1'b1;
    rxd   = 1'b1;
    model_rda = 1'b0;
    repeat (20) step_clk();
    send_frame(8'h0F, 1'b1, -1);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_frame_error();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
